fht_but_pipe: RTL and testbench

- Parametrised, pipelined radix-2 Hartley butterfly. Successor to the single-mode butterfly in the FHT datapath.
- Adds per-sample valid/stall control, internal X0 alignment, a stage-0 bypass mode, selectable output scaling, saturation with a sticky overflow flag, and a sideband tag.
- Sits between the FHT address/ROM sequencer and the ping-pong data RAMs, with one instance per butterfly lane.

---
 rtl/fht_but_pipe_pkg.sv | 23 ++
 rtl/fht_round_sat.sv | 54 +++++
 rtl/fht_but_pipe.sv | 139 +++++++++++++
 tb/tb_fht_but_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fht_but_pipe_pkg.sv
// ============================================================================
// fht_but_pipe_pkg : shared Q-format constants and default widths for the FHT
// Revision 1.0
// ============================================================================
`default_nettype none

package fht_but_pipe_pkg;

  localparam int D_BIT_DEF   = 17;
  localparam int W_BIT_DEF   = 12;
  localparam int TAG_BIT_DEF = 8;

  // Twiddles carry two integer bits (sign plus the unity bit).
  localparam int Q_FRAC   = W_BIT_DEF - 2;
  localparam int TW_UNITY = 1 << Q_FRAC;

  function automatic int q_frac(input int w_bit);
    return w_bit - 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fht_round_sat.sv
// ============================================================================
// fht_round_sat : arithmetic shift, round half away from zero, saturate
// Revision 1.0
// ============================================================================
`default_nettype none

module fht_round_sat #(
  parameter int IN_BIT  = 30,
  parameter int SHIFT   = 10,
  parameter int OUT_BIT = 17
) (
  input  logic signed [IN_BIT-1:0]  din,
  output logic signed [OUT_BIT-1:0] dout,
  output logic                      sat
);

  localparam int EW = IN_BIT + 1;
  localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_BIT+1){1'b0}}, {(OUT_BIT-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-OUT_BIT+1){1'b1}}, {(OUT_BIT-1){1'b0}}};

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rnd;

  assign ext = $signed({din[IN_BIT-1], din});

  generate
    if (SHIFT == 0) begin : g_pass
      assign rnd = ext;
    end else begin : g_round
      localparam logic signed [EW-1:0] HALF = EW'(1) << (SHIFT - 1);
      logic signed [EW-1:0] bias;
      logic signed [EW-1:0] biased;
      // Negative values take half-1 so that ties round away from zero.
      assign bias   = din[IN_BIT-1] ? (HALF - EW'(1)) : HALF;
      assign biased = ext + bias;
      assign rnd    = biased >>> SHIFT;
    end
  endgenerate

  always_comb begin
    dout = rnd[OUT_BIT-1:0];
    sat  = 1'b0;
    if (rnd > MAXV) begin
      dout = MAXV[OUT_BIT-1:0];
      sat  = 1'b1;
    end else if (rnd < MINV) begin
      dout = MINV[OUT_BIT-1:0];
      sat  = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fht_but_pipe.sv
// ============================================================================
// fht_but_pipe : two-stage radix-2 Hartley butterfly with stall, bypass,
//                scaling, saturation and sticky overflow
// Revision 1.0
// ============================================================================
`default_nettype none

module fht_but_pipe
  import fht_but_pipe_pkg::*;
#(
  parameter int D_BIT   = D_BIT_DEF,
  parameter int W_BIT   = W_BIT_DEF,
  parameter int TAG_BIT = TAG_BIT_DEF
) (
  input  logic                      iCLK,
  input  logic                      iRESET,
  input  logic                      iEN,
  input  logic                      iVALID,
  input  logic                      iBYPASS,
  input  logic                      iSCALE,
  input  logic                      iCLR_OVF,
  input  logic [TAG_BIT-1:0]        iTAG,
  input  logic signed [D_BIT-1:0]   iX_0,
  input  logic signed [D_BIT-1:0]   iX_1,
  input  logic signed [D_BIT-1:0]   iX_2,
  input  logic signed [W_BIT-1:0]   iSIN,
  input  logic signed [W_BIT-1:0]   iCOS,
  output logic signed [D_BIT-1:0]   oY_0,
  output logic signed [D_BIT-1:0]   oY_1,
  output logic                      oVALID,
  output logic [TAG_BIT-1:0]        oTAG,
  output logic                      oOVF
);

  localparam int PW = D_BIT + W_BIT + 1;
  localparam int QF = q_frac(W_BIT);

  logic signed [D_BIT-1:0]   x0_q, x0_d, r_q, r_d, y0_q, y0_d, y1_q, y1_d;
  logic                      scale_q, scale_d, v1_q, v1_d, v2_q, v2_d, ovf_q, ovf_d;
  logic [TAG_BIT-1:0]        tag1_q, tag1_d, tag2_q, tag2_d;

  logic signed [PW-1:0]      x1_e, x2_e, cos_e, sin_e, prod;
  logic signed [D_BIT-1:0]   prod_r, sum_r, dif_r;
  logic                      prod_sat, sum_sat, dif_sat, s1_sat;
  logic signed [D_BIT:0]     sum, dif;
  logic signed [D_BIT+1:0]   sum_in, dif_in;

  assign x1_e  = $signed({{(PW-D_BIT){iX_1[D_BIT-1]}}, iX_1});
  assign x2_e  = $signed({{(PW-D_BIT){iX_2[D_BIT-1]}}, iX_2});
  assign cos_e = $signed({{(PW-W_BIT){iCOS[W_BIT-1]}}, iCOS});
  assign sin_e = $signed({{(PW-W_BIT){iSIN[W_BIT-1]}}, iSIN});
  assign prod  = x1_e * cos_e + x2_e * sin_e;

  fht_round_sat #(.IN_BIT(PW), .SHIFT(QF), .OUT_BIT(D_BIT)) u_prod (
    .din(prod), .dout(prod_r), .sat(prod_sat)
  );

  assign s1_sat = prod_sat & ~iBYPASS;

  assign sum = $signed({x0_q[D_BIT-1], x0_q}) + $signed({r_q[D_BIT-1], r_q});
  assign dif = $signed({x0_q[D_BIT-1], x0_q}) - $signed({r_q[D_BIT-1], r_q});

  // Full scale is fed pre-doubled so the shared shift-by-one yields it exactly.
  assign sum_in = scale_q ? $signed({sum[D_BIT], sum}) : $signed({sum, 1'b0});
  assign dif_in = scale_q ? $signed({dif[D_BIT], dif}) : $signed({dif, 1'b0});

  fht_round_sat #(.IN_BIT(D_BIT+2), .SHIFT(1), .OUT_BIT(D_BIT)) u_sum (
    .din(sum_in), .dout(sum_r), .sat(sum_sat)
  );

  fht_round_sat #(.IN_BIT(D_BIT+2), .SHIFT(1), .OUT_BIT(D_BIT)) u_dif (
    .din(dif_in), .dout(dif_r), .sat(dif_sat)
  );

  always_comb begin
    x0_d    = x0_q;
    r_d     = r_q;
    scale_d = scale_q;
    tag1_d  = tag1_q;
    v1_d    = v1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    tag2_d  = tag2_q;
    v2_d    = v2_q;
    ovf_d   = ovf_q;
    if (iEN) begin
      x0_d    = iX_0;
      r_d     = iBYPASS ? iX_1 : prod_r;
      scale_d = iSCALE;
      tag1_d  = iTAG;
      v1_d    = iVALID;
      y0_d    = sum_r;
      y1_d    = dif_r;
      tag2_d  = tag1_q;
      v2_d    = v1_q;
    end
    if (iCLR_OVF) begin
      ovf_d = 1'b0;
    end
    if (iEN && ((iVALID && s1_sat) || (v1_q && (sum_sat || dif_sat)))) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      x0_q    <= '0;
      r_q     <= '0;
      scale_q <= 1'b0;
      tag1_q  <= '0;
      v1_q    <= 1'b0;
      y0_q    <= '0;
      y1_q    <= '0;
      tag2_q  <= '0;
      v2_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      x0_q    <= x0_d;
      r_q     <= r_d;
      scale_q <= scale_d;
      tag1_q  <= tag1_d;
      v1_q    <= v1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      tag2_q  <= tag2_d;
      v2_q    <= v2_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oY_0   = y0_q;
  assign oY_1   = y1_q;
  assign oTAG   = tag2_q;
  assign oVALID = v2_q;
  assign oOVF   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_fht_but_pipe.sv
// ============================================================================
// tb_fht_but_pipe : scoreboard bench for the pipelined Hartley butterfly
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fht_but_pipe;

  logic               clk;
  logic               iRESET, iEN, iVALID, iBYPASS, iSCALE, iCLR_OVF;
  logic [7:0]         iTAG, oTAG;
  logic signed [16:0] iX_0, iX_1, iX_2, oY_0, oY_1;
  logic signed [11:0] iSIN, iCOS;
  logic               oVALID, oOVF;

  fht_but_pipe dut (
    .iCLK(clk), .iRESET(iRESET), .iEN(iEN), .iVALID(iVALID), .iBYPASS(iBYPASS),
    .iSCALE(iSCALE), .iCLR_OVF(iCLR_OVF), .iTAG(iTAG), .iX_0(iX_0), .iX_1(iX_1),
    .iX_2(iX_2), .iSIN(iSIN), .iCOS(iCOS), .oY_0(oY_0), .oY_1(oY_1),
    .oVALID(oVALID), .oTAG(oTAG), .oOVF(oOVF)
  );

  typedef struct {
    logic       v;
    longint     y0;
    longint     y1;
    logic [7:0] tag;
    bit         mark;
  } item_t;

  item_t  q[$];
  item_t  hold;
  item_t  zero_item;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     adv_last = 0;
  bit     mon_en = 0;
  int     mark_in = 0;
  int     mark_out = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint rhaz(input longint v, input longint div);
    if (v >= 0) return (v + div / 2) / div;
    else return -((-v + div / 2) / div);
  endfunction

  function automatic longint sat17(input longint v);
    if (v > 65535) return 65535;
    if (v < -65536) return -65536;
    return v;
  endfunction

  function automatic item_t model(input longint x0, x1, x2, s, c, input bit v, byp, sc,
                                  input logic [7:0] tag, input bit mark);
    item_t  it;
    longint r, sm, df;
    r     = byp ? x1 : sat17(rhaz(x1 * c + x2 * s, 1024));
    sm    = x0 + r;
    df    = x0 - r;
    it.v    = v;
    it.y0   = sc ? rhaz(sm, 2) : sat17(sm);
    it.y1   = sc ? rhaz(df, 2) : sat17(df);
    it.tag  = tag;
    it.mark = mark;
    return it;
  endfunction

  task automatic step(input bit en, v, byp, sc, clr, input longint x0, x1, x2, s, c,
                      input logic [7:0] tag, input bit mark = 0);
    iEN = en; iVALID = v; iBYPASS = byp; iSCALE = sc; iCLR_OVF = clr;
    iX_0 = x0[16:0]; iX_1 = x1[16:0]; iX_2 = x2[16:0];
    iSIN = s[11:0]; iCOS = c[11:0]; iTAG = tag;
    if (en) q.push_back(model(x0, x1, x2, s, c, v, byp, sc, tag, mark));
    if (mark) mark_in = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  always @(posedge clk) begin
    cyc++;
    adv_last = iEN && iRESET;
  end

  // Outputs are compared every cycle against the last retired expectation,
  // so frozen outputs during a stall are covered too.
  always @(negedge clk) begin
    if (mon_en && iRESET) begin
      if (adv_last) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          hold = q.pop_front();
          if (hold.mark) mark_out = cyc;
        end
      end
      chk("oVALID", oVALID, hold.v);
      chk("oY_0", oY_0, hold.y0);
      chk("oY_1", oY_1, hold.y1);
      chk("oTAG", oTAG, hold.tag);
    end
  end

  initial begin
    zero_item = '{v: 1'b0, y0: 0, y1: 0, tag: 8'h00, mark: 1'b0};
    hold = zero_item;
    iRESET = 1; iEN = 1; iVALID = 0; iBYPASS = 0; iSCALE = 0; iCLR_OVF = 0;
    iTAG = 0; iX_0 = 0; iX_1 = 0; iX_2 = 0; iSIN = 0; iCOS = 0;
    #3 iRESET = 0;
    #1;
    chk("rst_oY_0", oY_0, 0);
    chk("rst_oY_1", oY_1, 0);
    chk("rst_oTAG", oTAG, 0);
    chk("rst_oVALID", oVALID, 0);
    chk("rst_oOVF", oOVF, 0);
    repeat (2) @(posedge clk);
    #1;
    q.push_back(zero_item);
    iRESET = 1;
    mon_en = 1;

    // Basic butterfly with output scaling.
    step(1, 1, 0, 1, 0, 50, 100, 0, 0, 1024, 8'hA5);
    // Product rounding ties, both signs.
    step(1, 1, 0, 0, 0, 0, 3, 0, 0, 512, 8'h11);
    step(1, 1, 0, 0, 0, 0, -3, 0, 0, 512, 8'h12);
    // Bypass ignores X2 and twiddles.
    step(1, 1, 1, 0, 0, 9, -7, 1234, -777, 345, 8'h13);
    repeat (3) idle();
    chk("ovf_quiet", oOVF, 0);

    // Stall for three cycles after tag 2 enters.
    step(1, 1, 0, 0, 0, 10, 20, 5, 100, 900, 8'd1);
    step(1, 1, 0, 1, 0, -30, 40, 0, 0, 1024, 8'd2, 1);
    repeat (3) step(0, 1, 1, 0, 0, 999, 999, 999, 999, 999, 8'hEE);
    step(1, 1, 0, 0, 0, 7, 8, 9, -300, 700, 8'd3);
    step(1, 1, 1, 1, 0, -11, 5, 0, 0, 0, 8'd4);
    step(1, 1, 0, 1, 0, 1000, -2000, 3000, 1023, -1024, 8'd5);
    repeat (3) idle();
    chk("stall_latency", mark_out - mark_in, 5);

    // Stage-2 saturation, sticky flag, clear.
    step(1, 1, 1, 0, 0, 65535, 1, 0, 0, 0, 8'h20);
    idle();
    chk("ovf_set", oOVF, 1);
    repeat (2) idle();
    chk("ovf_sticky", oOVF, 1);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    chk("ovf_clear", oOVF, 0);
    // Clear and set on the same edge: set wins.
    step(1, 1, 1, 0, 0, 65535, 1, 0, 0, 0, 8'h21);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    chk("ovf_clr_set", oOVF, 1);
    // Clear still works while stalled.
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    chk("ovf_clr_stall", oOVF, 0);
    // Invalid samples never set the flag.
    step(1, 0, 1, 0, 0, 65535, 1, 0, 0, 0, 8'h22);
    repeat (2) idle();
    chk("ovf_invalid", oOVF, 0);
    // Stage-1 product saturation on a valid sample.
    step(1, 1, 0, 1, 0, 0, -65536, -65536, -1024, -1024, 8'h23);
    repeat (2) idle();
    chk("ovf_stage1", oOVF, 1);

    // Asynchronous reset between clock edges with samples in flight.
    step(1, 1, 0, 0, 0, 100, 200, 0, 0, 1024, 8'h31);
    step(1, 1, 0, 0, 0, 300, 400, 0, 0, 1024, 8'h32);
    #2;
    iRESET = 0;
    #1;
    chk("arst_oY_0", oY_0, 0);
    chk("arst_oY_1", oY_1, 0);
    chk("arst_oTAG", oTAG, 0);
    chk("arst_oVALID", oVALID, 0);
    chk("arst_oOVF", oOVF, 0);
    iEN = 1; iVALID = 0;
    q.delete();
    q.push_back(zero_item);
    hold = zero_item;
    repeat (2) @(posedge clk);
    #1;
    iRESET = 1;
    repeat (3) idle();

    // Mixed-mode random traffic.
    for (int i = 0; i < 16; i++) begin
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
           longint'($urandom_range(0, 131071)) - 65536,
           longint'($urandom_range(0, 131071)) - 65536,
           longint'($urandom_range(0, 131071)) - 65536,
           longint'($urandom_range(0, 4095)) - 2048,
           longint'($urandom_range(0, 4095)) - 2048,
           8'($urandom_range(0, 255)));
    end
    repeat (3) idle();
    @(negedge clk);
    #1;
    chk("sb_drain", q.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
